cam_trigger_ctrl: RTL
=====================

Name: cam_trigger_ctrl

Overview:
- Parametrised multi-channel camera trigger controller.
- Runs off the 24 MHz camera-domain clock and replaces the separate clock-divider plus debounce pair.
- Contains an integrated sample prescaler, N-channel synchronise/debounce, rising-edge detection and a trigger-pulse FSM with guaranteed pulse width and holdoff.
- Supports manual, free-running and gated-free-running trigger modes; drives the sensor trigger pin.

Parameters:
- NCH, 2, number of button/trigger input channels (1..8).
- DB_DIV, 1200000, clk cycles per debounce sample tick (50 ms at 24 MHz); must be >= 2.
- DB_SAMPLES, 3, consecutive identical samples required to change a debounced level (>= 2).
- PULSE_W, 240, trig_out high time in clk cycles (10 us); must be >= 1.
- HOLDOFF, 24000, minimum low time after a pulse before the next can start (0 allowed).
- PERIOD, 800000, free-run trigger period in clk cycles (30 fps); must be > PULSE_W + HOLDOFF.
- CNT_W, 16, width of trig_count.

Ports:
- clk  in  1  24 MHz clock.
- reset  in  1  asynchronous, active-low reset.
- btn  in  NCH  raw asynchronous button/trigger inputs.
- en_mask  in  NCH  channel enable for trigger requests and the run gate.
- mode  in  2  00 disabled, 01 manual, 10 free-run, 11 gated free-run.
- btn_db  out  NCH  debounced channel levels.
- trig_out  out  1  sensor trigger pulse.
- busy  out  1  high while FSM is in PULSE or HOLDOFF.
- overrun  out  1  sticky flag: a request was dropped while busy.
- trig_count  out  CNT_W  number of pulses issued; wraps.

Behaviour:
- Reset (asynchronous, reset=0): all counters, synchronisers, shift registers, btn_db, trig_out, busy, overrun and trig_count go to 0; FSM goes to IDLE.
- Prescaler: counts 0..DB_DIV-1 and wraps. tick is high for exactly one cycle when count = DB_DIV-1.
- Synchroniser: each btn bit passes through a 2-flop synchroniser.
- Debounce sampling: on tick, the synchronised bit shifts into a per-channel DB_SAMPLES-bit register.
- Debounce decision (cycle after tick):
  - btn_db[i] <= 1 if the register is all ones.
  - btn_db[i] <= 0 if the register is all zeros.
  - Otherwise btn_db[i] holds its value.
- Edge detect: rise[i] = btn_db[i] & ~btn_db_q[i], high for one cycle.
- Request sources:
  - Manual (01): req = |(rise & en_mask).
  - Free-run (10): run = 1.
  - Gated free-run (11): run = |(btn_db & en_mask).
  - run=1: period counter pc counts 0..PERIOD-1 and wraps; req = (pc==0). The first trigger therefore fires the cycle run rises.
  - run=0: pc is held at 0.
  - Mode 00: req = 0, pc held at 0.
- req is registered (req_q) before it reaches the FSM.
- FSM states:
  - IDLE: req_q -> PULSE; next cycle trig_out=1, pulse counter = PULSE_W-1, trig_count increments.
  - PULSE: counter decrements. At 0: trig_out=0 and go to HOLDOFF with counter = HOLDOFF-1, or straight to IDLE if HOLDOFF=0.
  - HOLDOFF: counter decrements; at 0 go to IDLE.
- Pulse timing guarantees:
  - trig_out is high for exactly PULSE_W cycles.
  - From trig_out falling, the earliest next rise is HOLDOFF+1 cycles later.
- Latency:
  - Manual: btn_db rise at cycle n gives trig_out high at cycle n+2.
  - Free-run: pc==0 at cycle n gives trig_out high at n+2.
- Requests while busy:
  - req_q while in PULSE/HOLDOFF is dropped (not queued) and sets overrun.
  - A req_q in the same cycle the FSM returns to IDLE is also dropped.
- overrun clears only on reset or while mode==00.
- Mode change mid-pulse: the current pulse and holdoff always complete; there is no truncation. New mode requests apply from the next IDLE.
- Free-run sync: leaving free-run/gated mode, or gate falling, zeroes pc immediately.
- Wrap: trig_count wraps from 2^CNT_W-1 to 0 silently.
- Simultaneous rising edges on multiple enabled channels produce one request.

Test Plan:
(Bench parameters: NCH=2, DB_DIV=4, DB_SAMPLES=3, PULSE_W=5, HOLDOFF=10, PERIOD=40, CNT_W=4.)
- Reset mid-pulse: reset=0 while trig_out=1 -> trig_out, busy, trig_count, btn_db all 0 asynchronously. After release, FSM is in IDLE and no pulse occurs without a new request.
- Debounce, manual mode: mode=01, en_mask=01, btn[0] bounces 1-0-1 across ticks then holds 1 -> btn_db[0] rises only after 3 consecutive 1-samples. trig_out rises 2 cycles later and stays high 5 cycles; trig_count=1. A glitch shorter than 3 ticks never changes btn_db.
- Masking: mode=01, en_mask=01, clean press on btn[1] -> btn_db[1]=1 but no trigger; trig_count stays 0.
- Free-run: mode=10 for 200 cycles -> pulses start every 40 cycles, the first 2 cycles after mode entry. Each pulse is 5 cycles high; trig_count=5; overrun=0.
- Overrun: mode=01, second debounced press lands during HOLDOFF -> no second pulse, overrun=1. overrun persists until mode=00 for one cycle, then reads 0.
- Gated free-run plus wrap: mode=11, hold btn[0] for 17 periods -> 17 pulses and trig_count wraps to 1. Releasing btn_db[0] mid-pulse completes that pulse (5 cycles) and holdoff, then no further pulses.

Source files
------------

// File: rtl/cam_trigger_ctrl_if.sv
// Camera trigger controller signal bundle: button/mode inputs and trigger/status outputs.
// The master side drives the requests; the slave side is the controller.
interface cam_trigger_ctrl_if #(
  parameter int unsigned NCH   = 2,
  parameter int unsigned CNT_W = 16
);
  logic [NCH-1:0]   btn;
  logic [NCH-1:0]   en_mask;
  logic [1:0]       mode;
  logic [NCH-1:0]   btn_db;
  logic             trig_out;
  logic             busy;
  logic             overrun;
  logic [CNT_W-1:0] trig_count;

  modport master (
    output btn, en_mask, mode,
    input  btn_db, trig_out, busy, overrun, trig_count
  );

  modport slave (
    input  btn, en_mask, mode,
    output btn_db, trig_out, busy, overrun, trig_count
  );
endinterface

// File: rtl/cam_trigger_ctrl.sv
// Multi-channel camera trigger controller: prescaled debounce, edge detect,
// manual / free-run / gated free-run request generation and a pulse/holdoff FSM.
module cam_trigger_ctrl #(
  parameter int unsigned NCH        = 2,
  parameter int unsigned DB_DIV     = 1200000,
  parameter int unsigned DB_SAMPLES = 3,
  parameter int unsigned PULSE_W    = 240,
  parameter int unsigned HOLDOFF    = 24000,
  parameter int unsigned PERIOD     = 800000,
  parameter int unsigned CNT_W      = 16
) (
  input logic               clk,
  input logic               reset,
  cam_trigger_ctrl_if.slave bus
);

  localparam int unsigned DIV_W   = (DB_DIV > 2) ? $clog2(DB_DIV) : 1;
  localparam int unsigned PC_W    = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam int unsigned TMR_MAX = (PULSE_W > HOLDOFF) ? PULSE_W : HOLDOFF;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PULSE,
    S_HOLD
  } state_e;

  logic [DIV_W-1:0]      div_q, div_d;
  logic                  tick, tick_q;
  logic [NCH-1:0]        sync1_q, sync2_q;
  logic [DB_SAMPLES-1:0] sh_q [NCH];
  logic [NCH-1:0]        db_q, db_d, db_prev_q;
  logic [NCH-1:0]        rise;
  logic                  run, req, req_q;
  logic [PC_W-1:0]       pc_q, pc_d;

  state_e                state_q, state_d;
  logic [TMR_W-1:0]      tmr_q, tmr_d;
  logic                  trig_q, trig_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ovr_q, ovr_d;

  always_comb begin
    tick  = (div_q == DIV_W'(DB_DIV - 1));
    div_d = tick ? '0 : div_q + 1'b1;
  end

  // A level only changes once the sample window agrees unanimously.
  always_comb begin
    db_d = db_q;
    if (tick_q) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (&sh_q[i]) begin
          db_d[i] = 1'b1;
        end else if (~|sh_q[i]) begin
          db_d[i] = 1'b0;
        end
      end
    end
  end

  assign rise = db_q & ~db_prev_q;

  // pc restarts at 0 whenever run drops, so the first request lands on run's rising cycle.
  always_comb begin
    run  = 1'b0;
    req  = 1'b0;
    pc_d = '0;
    case (bus.mode)
      2'b01:   req = |(rise & bus.en_mask);
      2'b10:   run = 1'b1;
      2'b11:   run = |(db_q & bus.en_mask);
      default: ;
    endcase
    if (run) begin
      req  = (pc_q == '0);
      pc_d = (pc_q == PC_W'(PERIOD - 1)) ? '0 : pc_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    trig_d  = trig_q;
    cnt_d   = cnt_q;
    ovr_d   = ovr_q;
    case (state_q)
      S_IDLE: begin
        if (req_q) begin
          state_d = S_PULSE;
          tmr_d   = TMR_W'(PULSE_W - 1);
          trig_d  = 1'b1;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      S_PULSE: begin
        if (tmr_q == '0) begin
          trig_d = 1'b0;
          if (HOLDOFF == 0) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_HOLD;
            tmr_d   = TMR_W'(HOLDOFF - 1);
          end
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      S_HOLD: begin
        if (tmr_q == '0) begin
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (bus.mode == 2'b00) begin
      ovr_d = 1'b0;
    end else if (req_q && (state_q != S_IDLE)) begin
      ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q     <= '0;
      tick_q    <= 1'b0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        sh_q[i] <= '0;
      end
      db_q      <= '0;
      db_prev_q <= '0;
      pc_q      <= '0;
      req_q     <= 1'b0;
      state_q   <= S_IDLE;
      tmr_q     <= '0;
      trig_q    <= 1'b0;
      cnt_q     <= '0;
      ovr_q     <= 1'b0;
    end else begin
      div_q     <= div_d;
      tick_q    <= tick;
      sync1_q   <= bus.btn;
      sync2_q   <= sync1_q;
      if (tick) begin
        for (int unsigned i = 0; i < NCH; i++) begin
          sh_q[i] <= {sh_q[i][DB_SAMPLES-2:0], sync2_q[i]};
        end
      end
      db_q      <= db_d;
      db_prev_q <= db_q;
      pc_q      <= pc_d;
      req_q     <= req;
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      trig_q    <= trig_d;
      cnt_q     <= cnt_d;
      ovr_q     <= ovr_d;
    end
  end

  assign bus.btn_db     = db_q;
  assign bus.trig_out   = trig_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.overrun    = ovr_q;
  assign bus.trig_count = cnt_q;

endmodule
